shift194_tx_ctrl: RTL and testbench
===================================

Name: shift194_tx_ctrl

Overview:
Parallel-to-serial transmit sequencer that sits directly upstream of the 4-bit universal shift register (74HC194 model) and drives its S1/S0/D/Dsr/Dsl pins.
- Accepts a 4-bit word on a valid/ready handshake, commands a parallel load, then commands four shift steps in the selected direction.
- Reads the register's Q back and presents one serial bit per cycle with a valid strobe.
- Shares CP and CR with the shift register, so both clear together.

Parameters:
FILL, 1'b0, bit driven on Dsr/Dsl during shifts (fills vacated positions)
GAP, 1, idle cycles inserted after each word before Dready reasserts (0..7)
GAP_W, 3, width of gap counter

Ports:
CP  input  1  clock, rising-edge active
CR  input  1  asynchronous active-low reset
Din  input  4  word to transmit
Dvalid  input  1  Din valid
Dir  input  1  0 = MSB-first (shift toward Q[3]); 1 = LSB-first (shift toward Q[0]); sampled at acceptance
Dready  output  1  controller can accept a word
Q_fb  input  4  Q of downstream shift register
S1  output  1  shift register mode select high
S0  output  1  shift register mode select low
D  output  4  parallel load data to shift register
Dsr  output  1  serial input for {S1,S0}=01 (enters Q[0])
Dsl  output  1  serial input for {S1,S0}=10 (enters Q[3])
Sout  output  1  current serial bit
Sout_valid  output  1  Sout is a valid data bit
Busy  output  1  word in progress (LOAD, SHIFT or GAP)
Done  output  1  one-cycle pulse after last bit of a word

Behaviour:
- Interface: one clock CP; reset CR is asynchronous and active-low.
- States: IDLE, LOAD, SHIFT, GAP. Registers: state, word_reg[3:0], dir_reg, bit_cnt[1:0], gap_cnt[GAP_W-1:0], Done.
- Reset (CR=0, asynchronous): state=IDLE, word_reg=0, dir_reg=0, bit_cnt=0, gap_cnt=0, Done=0.
- Reset mid-word: abandons the word with no Done pulse. Dready=1 in the first cycle after CR releases.
- Outputs are decoded from state and are valid within the current cycle.
- IDLE:
  - Dready=1, {S1,S0}=00 (hold), D=0, Sout_valid=0, Busy=0.
  - On an edge with Dvalid&Dready: word_reg<=Din, dir_reg<=Dir, go to LOAD.
- LOAD (one cycle):
  - {S1,S0}=11, D=word_reg, Busy=1, Dready=0.
  - The shift register captures word_reg at the end of this cycle.
  - Next state is SHIFT, with bit_cnt<=0.
- SHIFT (exactly 4 cycles, bit_cnt 0..3):
  - Sout = dir_reg ? Q_fb[0] : Q_fb[3]; Sout_valid=1.
  - For bit_cnt<3: {S1,S0} = dir_reg ? 10 : 01.
  - For bit_cnt=3: {S1,S0}=00, so the register holds the word shifted by 3.
  - Dsr=Dsl=FILL in every state.
  - At the end of bit_cnt=3: Done<=1 for one cycle; next state is GAP if GAP>0, else IDLE.
- GAP: {S1,S0}=00, Busy=1, Dready=0. Counts GAP cycles, then returns to IDLE.
- Latency:
  - Acceptance edge at E0; LOAD in cycle E0..E1.
  - Bits are valid in cycles E1..E5.
  - Done is high in the cycle after the last bit.
- Throughput: one word per 6+GAP cycles, counting the IDLE acceptance cycle.
- Boundaries:
  - Dvalid while Busy is ignored (no queueing); the source must hold Dvalid until Dready.
  - Dir changes mid-word have no effect.
  - Dvalid arriving in the Done cycle with GAP=0 is accepted, because state is already IDLE.
  - Bit order:
    - MSB-first sends Din[3],Din[2],Din[1],Din[0].
    - LSB-first sends Din[0],Din[1],Din[2],Din[3].

Decomposition:
- Shared package (shift194_pkg): mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11, plus state encodings.
  - The shift register's case labels adopt the same constants.
- No sub-module in the controller: counters and FSM stay in one module.
- Benches instantiate the controller plus the existing 74HC194 model, with Q_fb tied to its Q.

Test Plan:
1. Din=4'b1011, Dir=0, GAP=1 -> LOAD with {S1,S0}=11, D=1011; Sout=1,0,1,1 on four Sout_valid cycles; {S1,S0}=01,01,01,00; Done one cycle later; Dready returns 2 cycles after last bit.
2. Din=4'b1011, Dir=1 -> Sout=1,1,0,1; {S1,S0}=10 during the first three SHIFT cycles; final Q=4'b0001 with FILL=0.
3. Dvalid held high continuously with words 0x5 then 0xA, GAP=0 -> second word accepted in the Done cycle; streams 0,1,0,1,1,0,1,0 with exactly 2 non-valid cycles between words.
4. CR pulsed low during SHIFT at bit_cnt=2 -> all outputs immediately go to IDLE values and register Q=0; no Done; Dready=1 after release; a new word 0xF transmits cleanly.
5. Dvalid asserted with Din=0x3 while Busy -> ignored; the in-flight word bits are unchanged and 0x3 is accepted only once Dready=1.
6. FILL=1, Din=0x0, Dir=0 -> Sout=0,0,0,0 and final Q_fb=4'b0111.

Source files
------------

// File: rtl/shift194_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift194_pkg : mode-pin codes and controller state encoding for the 74HC194 pair
// Rev 1.0
// ---------------------------------------------------------------------------
package shift194_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_GAP   = 2'b11
  } state_e;

endpackage
`default_nettype wire

// File: rtl/shift194.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift194 : 4-bit universal shift register (74HC194 behaviour), async clear
// Rev 1.0
// ---------------------------------------------------------------------------
module shift194
  import shift194_pkg::*;
(
  input  logic       CP,
  input  logic       CR,
  input  logic       S1,
  input  logic       S0,
  input  logic [3:0] D,
  input  logic       Dsr,
  input  logic       Dsl,
  output logic [3:0] Q
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // SHR moves data toward Q[3] with Dsr entering Q[0]; SHL is the mirror image
  always_comb begin
    q_d = q_q;
    case ({S1, S0})
      MODE_HOLD: q_d = q_q;
      MODE_SHR:  q_d = {q_q[2:0], Dsr};
      MODE_SHL:  q_d = {Dsl, q_q[3:1]};
      MODE_LOAD: q_d = D;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) q_q <= '0;
    else     q_q <= q_d;
  end

  assign Q = q_q;

endmodule
`default_nettype wire

// File: rtl/shift194_tx_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift194_tx_ctrl : valid/ready word intake, 194 load + 4 shifts, serial readback
// Rev 1.0
// ---------------------------------------------------------------------------
module shift194_tx_ctrl
  import shift194_pkg::*;
#(
  parameter logic FILL  = 1'b0,
  parameter int   GAP   = 1,
  parameter int   GAP_W = 3
) (
  input  logic       CP,
  input  logic       CR,
  input  logic [3:0] Din,
  input  logic       Dvalid,
  input  logic       Dir,
  output logic       Dready,
  input  logic [3:0] Q_fb,
  output logic       S1,
  output logic       S0,
  output logic [3:0] D,
  output logic       Dsr,
  output logic       Dsl,
  output logic       Sout,
  output logic       Sout_valid,
  output logic       Busy,
  output logic       Done
);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

  state_e           state_q,   state_d;
  logic [3:0]       word_q,    word_d;
  logic             dir_q,     dir_d;
  logic [1:0]       bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             done_q,    done_d;

  // Only the bit at the outgoing end of the register is ever read back
  logic unused_qfb;
  assign unused_qfb = ^Q_fb[2:1];

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    dir_d     = dir_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Dvalid) begin
          word_d  = Din;
          dir_d   = Dir;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        bit_cnt_d = bit_cnt_q + 2'd1;
        if (bit_cnt_q == 2'd3) begin
          done_d    = 1'b1;
          gap_cnt_d = '0;
          state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      dir_q     <= 1'b0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      dir_q     <= dir_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
    end
  end

  // Last SHIFT cycle holds, leaving the register at the word shifted by three
  always_comb begin
    Dready     = 1'b0;
    {S1, S0}   = MODE_HOLD;
    D          = '0;
    Sout       = 1'b0;
    Sout_valid = 1'b0;
    Busy       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        Dready = 1'b1;
        Busy   = 1'b0;
      end
      ST_LOAD: begin
        {S1, S0} = MODE_LOAD;
        D        = word_q;
      end
      ST_SHIFT: begin
        Sout_valid = 1'b1;
        Sout       = dir_q ? Q_fb[0] : Q_fb[3];
        if (bit_cnt_q != 2'd3) {S1, S0} = dir_q ? MODE_SHL : MODE_SHR;
      end
      default: ;
    endcase
  end

  assign Dsr  = FILL;
  assign Dsl  = FILL;
  assign Done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shift194_tx_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_shift194_tx_ctrl : controller + 194 pairs (inst0 FILL=0 GAP=1, inst1 FILL=1 GAP=0)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_shift194_tx_ctrl;

  localparam int N = 2;

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic logic fill_of(input int i);
    return (i == 0) ? 1'b0 : 1'b1;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       cr     [N];
  logic [3:0] din    [N];
  logic       dvalid [N];
  logic       dirv   [N];
  logic       dready [N];
  logic       s1     [N];
  logic       s0     [N];
  logic [3:0] d      [N];
  logic       dsr    [N];
  logic       dsl    [N];
  logic       sout   [N];
  logic       sv     [N];
  logic       busy   [N];
  logic       done   [N];
  logic [3:0] q      [N];

  shift194_tx_ctrl #(.FILL(1'b0), .GAP(1), .GAP_W(3)) u_ctrl0 (
    .CP(clk), .CR(cr[0]), .Din(din[0]), .Dvalid(dvalid[0]), .Dir(dirv[0]),
    .Dready(dready[0]), .Q_fb(q[0]), .S1(s1[0]), .S0(s0[0]), .D(d[0]),
    .Dsr(dsr[0]), .Dsl(dsl[0]), .Sout(sout[0]), .Sout_valid(sv[0]),
    .Busy(busy[0]), .Done(done[0]));

  shift194 u_reg0 (
    .CP(clk), .CR(cr[0]), .S1(s1[0]), .S0(s0[0]), .D(d[0]),
    .Dsr(dsr[0]), .Dsl(dsl[0]), .Q(q[0]));

  shift194_tx_ctrl #(.FILL(1'b1), .GAP(0), .GAP_W(3)) u_ctrl1 (
    .CP(clk), .CR(cr[1]), .Din(din[1]), .Dvalid(dvalid[1]), .Dir(dirv[1]),
    .Dready(dready[1]), .Q_fb(q[1]), .S1(s1[1]), .S0(s0[1]), .D(d[1]),
    .Dsr(dsr[1]), .Dsl(dsl[1]), .Sout(sout[1]), .Sout_valid(sv[1]),
    .Busy(busy[1]), .Done(done[1]));

  shift194 u_reg1 (
    .CP(clk), .CR(cr[1]), .S1(s1[1]), .S0(s0[1]), .D(d[1]),
    .Dsr(dsr[1]), .Dsl(dsl[1]), .Q(q[1]));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%0h required=%0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Model: t = cycles since acceptance (0 idle, 1 load, 2..5 bits, 6.. gap)
  int         t     [N];
  logic [3:0] w     [N];
  logic       md    [N];
  logic [3:0] qe    [N];
  logic       de    [N];

  task automatic mreset(input int i);
    t[i] = 0; w[i] = '0; md[i] = 1'b0; qe[i] = '0; de[i] = 1'b0;
  endtask

  task automatic mstep(input int i);
    int p;
    p = t[i];
    if (p == 1)                qe[i] = w[i];
    else if (p >= 2 && p <= 4) qe[i] = md[i] ? {fill_of(i), qe[i][3:1]} : {qe[i][2:0], fill_of(i)};
    de[i] = (p == 5);
    if (p == 0) begin
      if (dvalid[i]) begin t[i] = 1; w[i] = din[i]; md[i] = dirv[i]; end
    end else if (p >= 5 + gap_of(i)) t[i] = 0;
    else t[i] = p + 1;
  endtask

  always @(posedge clk) for (int i = 0; i < N; i++) if (cr[i]) mstep(i); else mreset(i);
  always @(negedge cr[0]) mreset(0);
  always @(negedge cr[1]) mreset(1);

  bit   run = 1'b0;
  int   cyc = 0;
  logic sq       [N][$];
  int   vc       [N][$];
  int   done_cnt [N];

  task automatic compare(input int i);
    int k;
    logic [1:0] sexp;
    k = t[i] - 2;
    if (t[i] == 1)                  sexp = 2'b11;
    else if (t[i] >= 2 && t[i] <= 4) sexp = md[i] ? 2'b10 : 2'b01;
    else                            sexp = 2'b00;
    chk("Dready", i, dready[i], t[i] == 0);
    chk("Busy", i, busy[i], t[i] != 0);
    chk("Sout_valid", i, sv[i], t[i] >= 2 && t[i] <= 5);
    chk("Done", i, done[i], de[i]);
    chk("S1S0", i, {s1[i], s0[i]}, sexp);
    chk("Dsr", i, dsr[i], fill_of(i));
    chk("Dsl", i, dsl[i], fill_of(i));
    chk("Q", i, q[i], qe[i]);
    if (t[i] <= 1) chk("D", i, d[i], (t[i] == 1) ? w[i] : 4'h0);
    if (t[i] >= 2 && t[i] <= 5) chk("Sout", i, sout[i], md[i] ? w[i][k] : w[i][3-k]);
  endtask

  always @(negedge clk) begin
    if (run) begin
      cyc++;
      for (int i = 0; i < N; i++) begin
        compare(i);
        if (sv[i] === 1'b1) begin sq[i].push_back(sout[i]); vc[i].push_back(cyc); end
        if (done[i] === 1'b1) done_cnt[i]++;
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clear(input int i);
    sq[i].delete(); vc[i].delete();
  endtask

  function automatic logic [31:0] pack(input int i);
    logic [31:0] v = '0;
    for (int j = 0; j < sq[i].size(); j++) v = {v[30:0], sq[i][j]};
    return v;
  endfunction

  // Returns in the LOAD cycle; Din/Dir are scrambled afterwards unless keep is set
  task automatic send(input int i, input logic [3:0] wv, input logic dv, input bit keep);
    int n = 0;
    din[i] = wv; dirv[i] = dv; dvalid[i] = 1'b1;
    while (!dready[i] && n < 40) begin step(); n++; end
    if (n >= 40) chk("accept_timeout", i, dready[i], 1);
    step();
    if (!keep) begin dvalid[i] = 1'b0; din[i] = ~wv; dirv[i] = ~dv; end
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (busy[i] && n < 40) begin step(); n++; end
    if (n >= 40) chk("idle_timeout", i, busy[i], 0);
    step(); step();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      cr[i] = 1'b1; din[i] = '0; dvalid[i] = 1'b0; dirv[i] = 1'b0; done_cnt[i] = 0;
    end
    #3;
    cr[0] = 1'b0; cr[1] = 1'b0;
    run = 1'b1;
    step(); step();
    chk("reset_Dready", 0, dready[0], 1);
    chk("reset_Busy", 1, busy[1], 0);
    chk("reset_Q", 0, q[0], 4'h0);
    cr[0] = 1'b1; cr[1] = 1'b1;
    step();

    // MSB-first 1011, GAP=1
    clear(0);
    send(0, 4'b1011, 1'b0, 0);
    wait_idle(0);
    chk("t1_stream", 0, pack(0), 32'b1011);
    chk("t1_bits", 0, sq[0].size(), 4);
    chk("t1_finalQ", 0, q[0], 4'b1000);
    chk("t1_done_cnt", 0, done_cnt[0], 1);

    // LSB-first 1011
    clear(0);
    send(0, 4'b1011, 1'b1, 0);
    wait_idle(0);
    chk("t2_stream", 0, pack(0), 32'b1101);
    chk("t2_finalQ", 0, q[0], 4'b0001);

    // Reset during the third bit abandons the word
    clear(0);
    send(0, 4'b1001, 1'b0, 0);
    step(); step();
    @(posedge clk); #2;
    cr[0] = 1'b0;
    #1;
    chk("t4_rst_Dready", 0, dready[0], 1);
    chk("t4_rst_Sout_valid", 0, sv[0], 0);
    chk("t4_rst_S1S0", 0, {s1[0], s0[0]}, 2'b00);
    chk("t4_rst_Q", 0, q[0], 4'h0);
    step();
    cr[0] = 1'b1;
    step();
    chk("t4_post_Dready", 0, dready[0], 1);
    chk("t4_aborted_bits", 0, sq[0].size(), 2);
    chk("t4_no_done", 0, done_cnt[0], 2);
    clear(0);
    send(0, 4'hF, 1'b0, 0);
    wait_idle(0);
    chk("t4_stream", 0, pack(0), 32'b1111);
    chk("t4_done_cnt", 0, done_cnt[0], 3);

    // 0x3 presented while busy waits for Dready
    clear(0);
    send(0, 4'b0110, 1'b0, 0);
    send(0, 4'h3, 1'b1, 0);
    wait_idle(0);
    chk("t5_stream", 0, pack(0), 32'b0110_1100);
    chk("t5_bits", 0, sq[0].size(), 8);

    // Back-to-back with GAP=0: second word accepted in the Done cycle
    clear(1);
    send(1, 4'h5, 1'b0, 1);
    send(1, 4'hA, 1'b0, 0);
    wait_idle(1);
    chk("t3_stream", 1, pack(1), 32'b0101_1010);
    chk("t3_bits", 1, sq[1].size(), 8);
    if (vc[1].size() == 8) chk("t3_gap", 1, vc[1][4] - vc[1][3], 3);
    else                   chk("t3_gap_size", 1, vc[1].size(), 8);
    chk("t3_done_cnt", 1, done_cnt[1], 2);

    // FILL=1 with a zero word
    clear(1);
    send(1, 4'h0, 1'b0, 0);
    wait_idle(1);
    chk("t6_stream", 1, pack(1), 32'b0000);
    chk("t6_finalQ", 1, q[1], 4'b0111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
`default_nettype wire
